// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the memory / write-back pipeline slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_wb_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W      = 5;

  // Control bundle carried alongside each instruction through EX/MEM.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  // A bubble is an instruction with every control deasserted.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // A ld/st whose byte address is not word aligned.
  function automatic logic is_misaligned(input ctrl_t c, input logic [1:0] addr_lsb);
    return (c.mem_read | c.mem_write) & (|addr_lsb);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: DEPTH x DATA_W, contents survive reset.
// Latency: read is combinational, write lands at the clock edge.
// Backpressure: none; the caller gates the write enable.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous word write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// EX/MEM register, data memory access and MEM/WB register with write-back select.
// Latency: ex_* -> ex_mem_* in 1 cycle, -> mem_wb_* in 2 cycles.
// Backpressure: stall holds both registers and blocks the store; flush bubbles EX/MEM.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_dest_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_mem_to_reg,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [REG_W-1:0]  ex_mem_dest_reg,
  output logic              ex_mem_reg_write,
  output logic              ex_mem_mem_read,
  output logic [DATA_W-1:0] mem_wb_write_back_result,
  output logic [REG_W-1:0]  mem_wb_dest_reg,
  output logic              mem_wb_reg_write,
  output logic              mem_wb_misaligned
);

  ctrl_t             ex_mem_ctrl;
  logic [DATA_W-1:0] ex_mem_store_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic [DATA_W-1:0] wb_data;

  // EX/MEM register: reset clears, stall holds, flush loads a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_ctrl       <= CTRL_BUBBLE;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_dest_reg   <= '0;
    end else if (!stall) begin
      if (flush) begin
        ex_mem_ctrl       <= CTRL_BUBBLE;
        ex_mem_alu_result <= '0;
        ex_mem_store_data <= '0;
        ex_mem_dest_reg   <= '0;
      end else begin
        ex_mem_ctrl       <= '{reg_write:  ex_reg_write,
                               mem_read:   ex_mem_read,
                               mem_write:  ex_mem_write,
                               mem_to_reg: ex_mem_to_reg};
        ex_mem_alu_result <= ex_alu_result;
        ex_mem_store_data <= ex_store_data;
        ex_mem_dest_reg   <= ex_dest_reg;
      end
    end
  end

  assign ex_mem_reg_write = ex_mem_ctrl.reg_write;
  assign ex_mem_mem_read  = ex_mem_ctrl.mem_read;

  // Word index wraps modulo DEPTH; a store commits only on the edge it leaves
  // EX/MEM, so stall and reset both suppress it, and misaligned stores are dropped.
  assign mem_addr = ex_mem_alu_result[ADDR_W+1:2];
  assign mem_we   = ex_mem_ctrl.mem_write && !stall && !reset &&
                    (ex_mem_alu_result[1:0] == 2'b00);

  data_memory #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (ex_mem_store_data),
    .rdata (mem_rdata)
  );

  // Write-back select: load data or ALU result.
  always_comb begin
    wb_data = ex_mem_alu_result;
    if (ex_mem_ctrl.mem_to_reg) begin
      wb_data = mem_rdata;
    end
  end

  // MEM/WB register: reset clears, stall holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wb_write_back_result <= '0;
      mem_wb_dest_reg          <= '0;
      mem_wb_reg_write         <= 1'b0;
      mem_wb_misaligned        <= 1'b0;
    end else if (!stall) begin
      mem_wb_write_back_result <= wb_data;
      mem_wb_dest_reg          <= ex_mem_dest_reg;
      mem_wb_reg_write         <= ex_mem_ctrl.reg_write;
      mem_wb_misaligned        <= is_misaligned(ex_mem_ctrl, ex_mem_alu_result[1:0]);
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ex_alu_result;
  logic [DW-1:0] ex_store_data;
  logic [4:0]    ex_dest_reg;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          stall;
  logic          flush;
  logic [DW-1:0] ex_mem_alu_result;
  logic [4:0]    ex_mem_dest_reg;
  logic          ex_mem_reg_write;
  logic          ex_mem_mem_read;
  logic [DW-1:0] mem_wb_write_back_result;
  logic [4:0]    mem_wb_dest_reg;
  logic          mem_wb_reg_write;
  logic          mem_wb_misaligned;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .ex_alu_result            (ex_alu_result),
    .ex_store_data            (ex_store_data),
    .ex_dest_reg              (ex_dest_reg),
    .ex_reg_write             (ex_reg_write),
    .ex_mem_read              (ex_mem_read),
    .ex_mem_write             (ex_mem_write),
    .ex_mem_to_reg            (ex_mem_to_reg),
    .stall                    (stall),
    .flush                    (flush),
    .ex_mem_alu_result        (ex_mem_alu_result),
    .ex_mem_dest_reg          (ex_mem_dest_reg),
    .ex_mem_reg_write         (ex_mem_reg_write),
    .ex_mem_mem_read          (ex_mem_mem_read),
    .mem_wb_write_back_result (mem_wb_write_back_result),
    .mem_wb_dest_reg          (mem_wb_dest_reg),
    .mem_wb_reg_write         (mem_wb_reg_write),
    .mem_wb_misaligned        (mem_wb_misaligned)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } instr_t;

  instr_t      m_exm;
  logic [31:0] m_wb;
  logic [4:0]  m_wb_dest;
  logic        m_wb_rw;
  logic        m_wb_mis;
  bit          m_wb_known;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];

  function automatic int widx(input logic [31:0] byte_addr);
    return int'((byte_addr / 32'd4) % DEPTH);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_exm      <= '0;
      m_wb       <= '0;
      m_wb_dest  <= '0;
      m_wb_rw    <= 1'b0;
      m_wb_mis   <= 1'b0;
      m_wb_known <= 1'b1;
    end else if (!stall) begin
      if (m_exm.mw && (m_exm.alu % 4 == 0)) begin
        m_mem[widx(m_exm.alu)]   <= m_exm.sd;
        m_known[widx(m_exm.alu)] <= 1'b1;
      end
      if (m_exm.m2r) begin
        m_wb       <= m_mem[widx(m_exm.alu)];
        m_wb_known <= m_known[widx(m_exm.alu)];
      end else begin
        m_wb       <= m_exm.alu;
        m_wb_known <= 1'b1;
      end
      m_wb_dest <= m_exm.dest;
      m_wb_rw   <= m_exm.rw;
      m_wb_mis  <= (m_exm.mr || m_exm.mw) && (m_exm.alu % 4 != 0);
      if (flush)
        m_exm <= '0;
      else
        m_exm <= '{ex_alu_result, ex_store_data, ex_dest_reg,
                   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_exm_alu",  ex_mem_alu_result,       m_exm.alu);
      chk("m_exm_dest", 32'(ex_mem_dest_reg),    32'(m_exm.dest));
      chk("m_exm_rw",   32'(ex_mem_reg_write),   32'(m_exm.rw));
      chk("m_exm_mr",   32'(ex_mem_mem_read),    32'(m_exm.mr));
      if (m_wb_known)
        chk("m_wb_res", mem_wb_write_back_result, m_wb);
      chk("m_wb_dest",  32'(mem_wb_dest_reg),    32'(m_wb_dest));
      chk("m_wb_rw",    32'(mem_wb_reg_write),   32'(m_wb_rw));
      chk("m_wb_mis",   32'(mem_wb_misaligned),  32'(m_wb_mis));
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dest,
                       input logic rw, input logic mr, input logic mw, input logic m2r);
    ex_alu_result = alu;
    ex_store_data = sd;
    ex_dest_reg   = dest;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_mem_to_reg = m2r;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    issue(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sw(input logic [31:0] addr, input logic [31:0] data);
    issue(addr, data, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic lw(input logic [31:0] addr, input logic [4:0] dest);
    issue(addr, 32'h0, dest, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_exm_alu"}, ex_mem_alu_result, 32'h0);
    chk({tag, "_exm_rw"},  32'(ex_mem_reg_write), 32'h0);
    chk({tag, "_exm_mr"},  32'(ex_mem_mem_read), 32'h0);
    chk({tag, "_exm_dst"}, 32'(ex_mem_dest_reg), 32'h0);
    chk({tag, "_wb_res"},  mem_wb_write_back_result, 32'h0);
    chk({tag, "_wb_dst"},  32'(mem_wb_dest_reg), 32'h0);
    chk({tag, "_wb_rw"},   32'(mem_wb_reg_write), 32'h0);
    chk({tag, "_wb_mis"},  32'(mem_wb_misaligned), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_dest_reg   = '0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
    ex_mem_to_reg = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset  = 1'b0;
    chk_en = 1'b1;

    // Seed known memory words.
    sw(32'h40, 32'h0000_1111);
    sw(32'h20, 32'h1234_0000);
    sw(32'h00, 32'hCAFE_0001);
    sw(32'h80, 32'h0000_2222);
    nop();

    // 1: ALU op pass-through.
    issue(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_exm_alu", ex_mem_alu_result, 32'h1234);
    nop();
    chk("t1_wb_res", mem_wb_write_back_result, 32'h1234);
    chk("t1_wb_dst", 32'(mem_wb_dest_reg), 32'd5);
    chk("t1_wb_rw",  32'(mem_wb_reg_write), 32'd1);

    // 2: store then load to the same address on consecutive cycles.
    sw(32'h10, 32'hDEAD_BEEF);
    lw(32'h10, 5'd7);
    nop();
    chk("t2_wb_res", mem_wb_write_back_result, 32'hDEAD_BEEF);
    chk("t2_wb_dst", 32'(mem_wb_dest_reg), 32'd7);

    // 3: stall for three cycles with a store sitting in EX/MEM.
    sw(32'h40, 32'h0000_A5A5);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(32'h999, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t3_hold_alu", ex_mem_alu_result, 32'h40);
      chk("t3_hold_mem", dut.u_mem.mem[16], 32'h0000_1111);
    end
    stall = 1'b0;
    issue(32'h999, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_rel_alu", ex_mem_alu_result, 32'h999);
    chk("t3_rel_mem", dut.u_mem.mem[16], 32'h0000_A5A5);
    lw(32'h40, 5'd9);
    nop();
    chk("t3_readback", mem_wb_write_back_result, 32'h0000_A5A5);

    // 4: flushed store never commits.
    flush = 1'b1;
    issue(32'h20, 32'h55, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    flush = 1'b0;
    chk("t4_exm_rw", 32'(ex_mem_reg_write), 32'd0);
    nop();
    chk("t4_wb_rw", 32'(mem_wb_reg_write), 32'd0);
    lw(32'h20, 5'd2);
    nop();
    chk("t4_readback", mem_wb_write_back_result, 32'h1234_0000);

    // 5: misaligned store dropped, flag for one cycle; address wrap.
    sw(32'h13, 32'h77);
    nop();
    chk("t5_mis_on", 32'(mem_wb_misaligned), 32'd1);
    nop();
    chk("t5_mis_off", 32'(mem_wb_misaligned), 32'd0);
    lw(32'h13, 5'd4);
    nop();
    chk("t5_mis_ld", mem_wb_write_back_result, 32'hDEAD_BEEF);
    lw(32'(DEPTH * 4), 5'd8);
    nop();
    chk("t5_wrap", mem_wb_write_back_result, 32'hCAFE_0001);

    // 6: reset with a store in EX/MEM.
    sw(32'h80, 32'h0000_BBBB);
    reset = 1'b1;
    nop();
    chk_all_zero("t6");
    reset = 1'b0;
    lw(32'h80, 5'd1);
    nop();
    chk("t6_readback", mem_wb_write_back_result, 32'h0000_2222);

    // Register 0 write passes through.
    issue(32'hABCD, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();
    chk("r0_rw", 32'(mem_wb_reg_write), 32'd1);

    nop();
    nop();
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
